// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO client and the fifo_ctrl engine.
// The master side issues wr_en/rd_en; the slave side (fifo_ctrl) returns
// operation state, occupancy, pointers and register-file strobes.
interface fifo_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  wr_en;
   logic                  rd_en;
   logic [2:0]            state;
   logic [ADDR_WIDTH:0]   data_count;
   logic [ADDR_WIDTH-1:0] head;
   logic [ADDR_WIDTH-1:0] tail;
   logic                  we;
   logic                  re;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;

   modport master (
      output wr_en, rd_en,
      input  state, data_count, head, tail, we, re, wr_addr, rd_addr
   );

   modport slave (
      input  wr_en, rd_en,
      output state, data_count, head, tail, we, re, wr_addr, rd_addr
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Control/write-side engine of the 2**ADDR_WIDTH-entry FIFO: decodes each
// cycle's request into an operation state, keeps occupancy and pointers,
// and drives the register-file strobes.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  INIT     | just reset, no request seen yet
//  NO_OP    | idle, or simultaneous write+read rejected
//  WRITE    | write accepted last edge
//  WR_ERROR | write refused, FIFO was full
//  READ     | read accepted last edge
//  RD_ERROR | read refused, FIFO was empty
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 3
) (
   input  logic        clk,
   input  logic        reset,
   fifo_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      INIT     = 3'b000,
      NO_OP    = 3'b001,
      WRITE    = 3'b010,
      WR_ERROR = 3'b011,
      READ     = 3'b100,
      RD_ERROR = 3'b101
   } state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] head_q, head_d;
   logic [ADDR_WIDTH-1:0] tail_q, tail_d;
   logic                  full, empty;
   logic                  we, re;

   // Full/empty come from occupancy only; pointers are equal in both cases.
   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);

   // Strobes are same-cycle so the register file captures on the same edge
   // that advances the pointer.
   assign we = bus.wr_en & ~bus.rd_en & ~full  & ~reset;
   assign re = bus.rd_en & ~bus.wr_en & ~empty & ~reset;

   // Next-state decode of the request against current occupancy.
   always_comb begin
      state_d = NO_OP;
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case ({bus.wr_en, bus.rd_en})
         2'b10:   state_d = full  ? WR_ERROR : WRITE;
         2'b01:   state_d = empty ? RD_ERROR : READ;
         default: state_d = NO_OP;
      endcase
      if (we) begin
         tail_d  = tail_q + PTR_ONE;
         count_d = count_q + CNT_ONE;
      end
      if (re) begin
         head_d  = head_q + PTR_ONE;
         count_d = count_q - CNT_ONE;
      end
   end

   // State and counters register; reset discards all occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.data_count = count_q;
   assign bus.head       = head_q;
   assign bus.tail       = tail_q;
   assign bus.we         = we;
   assign bus.re         = re;
   assign bus.wr_addr    = tail_q;
   assign bus.rd_addr    = head_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a fill/overflow/drain/underflow vector table, a few
// hand sequences for corner cases, and a random run against an occupancy model.
module tb_fifo_ctrl;

   localparam int AW = 3;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model: occupancy and pointers as plain integers
   int m_cnt = 0;
   int m_head = 0;
   int m_tail = 0;
   int m_state = 0;

   // strobes sampled just before the edge of the last step
   int s_we, s_re, s_rd_addr, s_wr_addr;

   typedef struct {
      bit rst;
      bit wr;
      bit rd;
      int e_we;
      int e_re;
      int e_state;
      int e_cnt;
      int e_head;
      int e_tail;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, check strobes, then check registers after edge.
   task automatic step(input bit rst, input bit wr, input bit rd);
      int e_we, e_re;
      @(negedge clk);
      reset = rst;
      bus.wr_en = wr;
      bus.rd_en = rd;
      #1;
      e_we = (!rst && wr && !rd && m_cnt != DEPTH) ? 1 : 0;
      e_re = (!rst && rd && !wr && m_cnt != 0) ? 1 : 0;
      s_we = int'(bus.we);
      s_re = int'(bus.re);
      s_rd_addr = int'(bus.rd_addr);
      s_wr_addr = int'(bus.wr_addr);
      chk("model_we", s_we, e_we);
      chk("model_re", s_re, e_re);
      if (rst) begin
         m_state = 0; m_cnt = 0; m_head = 0; m_tail = 0;
      end else if (wr && !rd) begin
         if (m_cnt == DEPTH) m_state = 3;
         else begin m_state = 2; m_cnt++; m_tail = (m_tail + 1) % DEPTH; end
      end else if (rd && !wr) begin
         if (m_cnt == 0) m_state = 5;
         else begin m_state = 4; m_cnt--; m_head = (m_head + 1) % DEPTH; end
      end else begin
         m_state = 1;
      end
      @(posedge clk);
      #1;
      chk("model_state", int'(bus.state), m_state);
      chk("model_count", int'(bus.data_count), m_cnt);
      chk("model_head", int'(bus.head), m_head);
      chk("model_tail", int'(bus.tail), m_tail);
      chk("model_rd_addr", int'(bus.rd_addr), m_head);
      chk("model_wr_addr", int'(bus.wr_addr), m_tail);
   endtask

   initial begin
      vec_t v;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;

      // reset with wr_en held
      v = '{1, 1, 0, 0, 0, 0, 0, 0, 0}; vecs.push_back(v);
      // fill: 8 accepted writes
      for (int i = 1; i <= 8; i++) begin
         v = '{0, 1, 0, 1, 0, 2, i, 0, i % 8}; vecs.push_back(v);
      end
      // overflow
      v = '{0, 1, 0, 0, 0, 3, 8, 0, 0}; vecs.push_back(v);
      // simultaneous request on full
      v = '{0, 1, 1, 0, 0, 1, 8, 0, 0}; vecs.push_back(v);
      // drain: 8 accepted reads
      for (int i = 1; i <= 8; i++) begin
         v = '{0, 0, 1, 0, 1, 4, 8 - i, i % 8, 0}; vecs.push_back(v);
      end
      // underflow, then idle
      v = '{0, 0, 1, 0, 0, 5, 0, 0, 0}; vecs.push_back(v);
      v = '{0, 0, 0, 0, 0, 1, 0, 0, 0}; vecs.push_back(v);

      repeat (2) @(posedge clk);

      foreach (vecs[k]) begin
         step(vecs[k].rst, vecs[k].wr, vecs[k].rd);
         chk($sformatf("vec%0d_we", k), s_we, vecs[k].e_we);
         chk($sformatf("vec%0d_re", k), s_re, vecs[k].e_re);
         chk($sformatf("vec%0d_state", k), int'(bus.state), vecs[k].e_state);
         chk($sformatf("vec%0d_count", k), int'(bus.data_count), vecs[k].e_cnt);
         chk($sformatf("vec%0d_head", k), int'(bus.head), vecs[k].e_head);
         chk($sformatf("vec%0d_tail", k), int'(bus.tail), vecs[k].e_tail);
      end

      // simultaneous request at count 3 leaves everything alone
      step(1, 0, 0);
      repeat (3) step(0, 1, 0);
      step(0, 1, 1);
      chk("simul_we", s_we, 0);
      chk("simul_re", s_re, 0);
      chk("simul_state", int'(bus.state), 1);
      chk("simul_count", int'(bus.data_count), 3);
      chk("simul_tail", int'(bus.tail), 3);
      chk("simul_head", int'(bus.head), 0);
      step(0, 0, 0);
      chk("idle_state", int'(bus.state), 1);

      // pointer wrap: write 5, read 5, write 5
      step(1, 0, 0);
      repeat (5) step(0, 1, 0);
      repeat (5) step(0, 0, 1);
      step(0, 1, 0);
      step(0, 1, 0);
      chk("wrap_tail7", int'(bus.tail), 7);
      step(0, 1, 0);
      chk("wrap_tail0", int'(bus.tail), 0);
      step(0, 1, 0);
      step(0, 1, 0);
      chk("wrap_tail2", int'(bus.tail), 2);
      chk("wrap_count", int'(bus.data_count), 5);
      step(0, 0, 1);
      chk("wrap_rd_addr", s_rd_addr, 5);
      chk("wrap_re", s_re, 1);

      // reset mid-stream with rd_en held
      step(1, 0, 0);
      repeat (4) step(0, 1, 0);
      chk("mid_fill_count", int'(bus.data_count), 4);
      step(1, 0, 1);
      chk("mid_rst_re", s_re, 0);
      chk("mid_rst_state", int'(bus.state), 0);
      chk("mid_rst_count", int'(bus.data_count), 0);
      chk("mid_rst_head", int'(bus.head), 0);
      chk("mid_rst_tail", int'(bus.tail), 0);
      step(0, 0, 1);
      chk("mid_rd_err_state", int'(bus.state), 5);

      // random traffic against the model, write-biased and read-biased phases
      for (int n = 0; n < 3000; n++) begin
         bit r_rst, r_wr, r_rd;
         int bias;
         bias = (n / 500) % 2 == 0 ? 70 : 30;
         r_rst = ($urandom_range(0, 199) == 0);
         r_wr = ($urandom_range(0, 99) < bias);
         r_rd = ($urandom_range(0, 99) < (100 - bias));
         step(r_rst, r_wr, r_rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control/write-side engine of the 8-entry FIFO.
- Accepts wr_en/rd_en requests each clock and computes the next operation state.
- Maintains data_count and the head/tail pointers, and drives register-file write/read strobes and addresses.
- Its state and data_count outputs are exactly the inputs consumed by the FIFO status decoder (full/empty/ack/err flags).

Parameters:
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8. data_count width is ADDR_WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request, sampled at rising edge
- rd_en  input  1  read request, sampled at rising edge
- state  output  3  registered operation state (encoding below)
- data_count  output  ADDR_WIDTH+1  registered occupancy, 0..8
- head  output  ADDR_WIDTH  registered read pointer
- tail  output  ADDR_WIDTH  registered write pointer
- we  output  1  combinational register-file write strobe
- re  output  1  combinational register-file read strobe
- wr_addr  output  ADDR_WIDTH  equals tail
- rd_addr  output  ADDR_WIDTH  equals head

Behaviour:
- State encoding: INIT=3'b000, NO_OP=3'b001, WRITE=3'b010, WR_ERROR=3'b011, READ=3'b100, RD_ERROR=3'b101. Codes 110/111 are never produced.
- Reset (reset=1 at a rising edge) forces: state=INIT, data_count=0, head=0, tail=0. Reset has priority over wr_en/rd_en; we=re=0 while reset=1.
- Next-state decode uses the current registered data_count:
  - wr_en=1, rd_en=0: if data_count==8, go to WR_ERROR; otherwise go to WRITE.
  - rd_en=1, wr_en=0: if data_count==0, go to RD_ERROR; otherwise go to READ.
  - wr_en=rd_en=0: go to NO_OP.
  - wr_en=rd_en=1: go to NO_OP. Simultaneous requests are rejected with no pointer or count change.
- INIT is left on the first non-reset edge via the same decode; there is no special INIT transition.
- Combinational strobes (same cycle as the request, so the memory captures at the same edge):
  - we = wr_en & ~rd_en & (data_count!=8) & ~reset
  - re = rd_en & ~wr_en & (data_count!=0) & ~reset
- Registered updates at the edge where the strobe is high:
  - we: tail <= tail+1 (mod 8), data_count <= data_count+1.
  - re: head <= head+1 (mod 8), data_count <= data_count-1.
- Pointer wrap: 7 -> 0 with no flag. Full and empty are distinguished only by data_count (8 vs 0), never by pointer equality.
- data_count never exceeds 8 and never underflows below 0. Error states leave all counters unchanged.
- Error and ack states persist only for one cycle per request; a held wr_en on a full FIFO stays in WR_ERROR every cycle.
- Latency: a request at edge N is reflected in state/data_count/pointers immediately after edge N, i.e. visible in cycle N+1.
- Reset asserted mid-stream discards all occupancy: count=0, pointers=0 on that edge. Register-file contents are not cleared.

Test Plan:
- Reset with wr_en=1 held -> after the edge: state=000, data_count=0, head=0, tail=0, we=0.
- From reset, 8 consecutive wr_en cycles -> state=010 each cycle, data_count=1..8, tail 1..7 then 0; ninth wr_en -> state=011, data_count stays 8, we=0, tail stays 0.
- From full, 8 rd_en cycles -> state=100, data_count 7..0, head wraps to 0; ninth rd_en -> state=101, re=0, data_count=0.
- wr_en=rd_en=1 with data_count=3 -> state=001, data_count=3, pointers unchanged, we=re=0. Idle cycle -> state=001.
- Wrap check: write 5, read 5, write 5 -> tail=7 then 0,1,2; data_count=5; rd_addr=5 on the next read.
- Fill to 4, assert reset for 1 cycle with rd_en=1 -> state=000, data_count=0, head=tail=0. Next rd_en -> state=101.
